regfile_scoreboard: RTL
=======================

# regfile_scoreboard

Parametrised multi-register file for the pipelined core, with two combinational read ports, one write port, optional write-to-read bypass and a per-register scoreboard of pending writes. The decode stage marks destination registers as pending at issue. Writeback clears them. The busy outputs let the hazard unit stall on read-after-write dependencies. It replaces the fixed 32x32 file and adds reset, bypass and hazard tracking.

## Interface
Parameters:
- DATA_WIDTH, 32, register and data-bus width
- ADDR_WIDTH, 5, address width; depth = 2^ADDR_WIDTH
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never pending
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports and busy flags

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous and active-high
- reg_write  in  1  write enable for writeback
- write_address  in  ADDR_WIDTH  writeback destination
- write  in  DATA_WIDTH  writeback data
- read1_address, read2_address  in  ADDR_WIDTH  read port addresses
- read1, read2  out  DATA_WIDTH  read data, combinational
- issue_valid  in  1  an instruction with a destination issues this cycle
- issue_address  in  ADDR_WIDTH  destination of the issuing instruction
- read1_busy, read2_busy  out  1  the addressed register has a pending, un-bypassed write
- pending_count  out  ADDR_WIDTH+1  number of registers currently pending

## Operation
- Storage is 2^ADDR_WIDTH x DATA_WIDTH data plus a 2^ADDR_WIDTH-bit pending vector and the pending_count counter.
- Write: if reg_write is high and write_address is not a ZERO_REG-protected 0, the register takes the value of write at the edge.
- Read of readN_address:
  - If ZERO_REG and the address is 0, the read returns 0.
  - Otherwise, if BYPASS and reg_write is high and write_address equals the read address, the read returns write.
  - Otherwise the read returns the stored value.
- Busy: readN_busy = pending[addr] AND NOT (BYPASS AND reg_write AND write_address == addr). With ZERO_REG, address 0 is never busy.
- Pending update per edge. An effective issue is issue_valid with a non-zero address when ZERO_REG is set. An effective write is defined the same way.
  - An effective issue sets pending[issue_address].
  - An effective write clears pending[write_address], unless the same edge issues to that address. In that case the set wins, because a new producer is in flight.
  - A write to a non-pending register updates data only. It is not an error.
  - Issue and write to different addresses take effect independently.
- pending_count:
  - +1 when an issue sets a bit that was clear.
  - -1 when a write clears a bit that was set.
  - Both on one edge to different addresses: net 0.
  - Same address, bit previously set: unchanged.
  - Same address, bit previously clear: +1.
  - The count always equals the popcount of the pending vector. It never exceeds 2^ADDR_WIDTH (or 2^ADDR_WIDTH-1 with ZERO_REG), and it never wraps.
- Reset has priority over issue and write. On the reset edge all registers become 0, all pending bits clear, and pending_count becomes 0. Writes and issues presented on the reset cycle are discarded.

## Timing
- Reset values:
  - read1 and read2 are 0 for any address.
  - read1_busy, read1_busy and read2_busy are 0.
  - pending_count is 0.
- Read latency is 0 cycles, a purely combinational path from address (and, with BYPASS, from write/write_address).
- Write latency is 1 edge. Without BYPASS, a same-cycle read returns the old value and the new value appears in the cycle after the edge.
- Issue-to-busy latency is 1 edge. The register reads busy from the cycle after issue until the cycle of its writeback. With BYPASS the busy flag drops in the writeback cycle itself. Without BYPASS it drops in the following cycle.
- Reset asserted mid-operation clears everything on that edge. Any in-flight writebacks arriving afterwards are applied as ordinary writes to non-pending registers and do not decrement the count.

## Test plan
- Reset, then read all addresses: every read returns 0, busy flags are 0, pending_count = 0.
- Write 0xDEADBEEF to r5, then read r5 on the next cycle: returns 0xDEADBEEF. Write 0x1234 to r0 with ZERO_REG=1: r0 still reads 0.
- BYPASS=1, write 0xA5A5A5A5 to r7 while read1_address = 7: read1 = 0xA5A5A5A5 in the same cycle. With BYPASS=0, read1 shows the old value and then 0xA5A5A5A5 one cycle later.
- Issue r3, then check busy: read1_busy = 1 and pending_count = 1 from the next cycle. Writeback r3: busy drops (the same cycle with BYPASS=1) and the count returns to 0.
- Issue r9 and write r9 on the same edge while r9 is pending: r9 stays pending and the count is unchanged. Issue r4 plus write r9 on one edge: r4 becomes pending, r9 clears, net count unchanged.
- Issue r1, r2, r3, then assert rst together with a write to r2: all pending bits clear, pending_count = 0, r2 reads 0. Issue every address: count reaches 31 with ZERO_REG=1 and 32 with ZERO_REG=0, with no wrap.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port, optional
// write-to-read bypass and a per-register pending-write scoreboard.
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write,
  input  logic [ADDR_WIDTH-1:0] read1_address,
  input  logic [ADDR_WIDTH-1:0] read2_address,
  output logic [DATA_WIDTH-1:0] read1,
  output logic [DATA_WIDTH-1:0] read2,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_address,
  output logic                  read1_busy,
  output logic                  read2_busy,
  output logic [ADDR_WIDTH:0]   pending_count
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      r_pending;
  logic [ADDR_WIDTH:0]   r_count;

  logic            w_wr_eff;
  logic            w_iss_eff;
  logic            w_inc;
  logic            w_dec;
  logic            w_fwd1;
  logic            w_fwd2;
  logic [DEPTH-1:0] w_pending_nxt;

  assign w_wr_eff  = reg_write   && !((ZERO_REG != 0) && (write_address == '0));
  assign w_iss_eff = issue_valid && !((ZERO_REG != 0) && (issue_address == '0));

  // A same-edge issue to the written register keeps it pending, so the
  // decrement only applies when the issue targets a different register.
  assign w_inc = w_iss_eff && !r_pending[issue_address];
  assign w_dec = w_wr_eff && r_pending[write_address] &&
                 !(w_iss_eff && (issue_address == write_address));

  always_comb begin
    w_pending_nxt = r_pending;
    if (w_wr_eff)  w_pending_nxt[write_address] = 1'b0;
    if (w_iss_eff) w_pending_nxt[issue_address] = 1'b1;
  end

  assign w_fwd1 = (BYPASS != 0) && reg_write && (write_address == read1_address);
  assign w_fwd2 = (BYPASS != 0) && reg_write && (write_address == read2_address);

  always_comb begin
    read1 = r_mem[read1_address];
    if ((ZERO_REG != 0) && (read1_address == '0)) read1 = '0;
    else if (w_fwd1)                              read1 = write;
  end

  always_comb begin
    read2 = r_mem[read2_address];
    if ((ZERO_REG != 0) && (read2_address == '0)) read2 = '0;
    else if (w_fwd2)                              read2 = write;
  end

  assign read1_busy = r_pending[read1_address] && !w_fwd1;
  assign read2_busy = r_pending[read2_address] && !w_fwd2;
  assign pending_count = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_pending <= '0;
      r_count   <= '0;
    end else begin
      if (w_wr_eff) r_mem[write_address] <= write;
      r_pending <= w_pending_nxt;
      if (w_inc && !w_dec)      r_count <= r_count + 1'b1;
      else if (w_dec && !w_inc) r_count <= r_count - 1'b1;
    end
  end

endmodule
